// File: rtl/packet_mem_reader.sv
// ============================================================================
// packet_mem_reader
// ----------------------------------------------------------------------------
// Transmit-side packet memory reader. Pops packet lengths from a
// first-word-fall-through length FIFO. For each length it reads the matching
// bytes from the packet memory, starting at its own read-base pointer, and
// streams them out as a byte-wide tx stream. After each packet it inserts
// pIFG idle cycles.
//
// Ports:
//   iclk            clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_enable        allows new packets to start (in-flight packets complete)
//   i_fifo_empty    length FIFO empty flag
//   i_fifo_len      length FIFO head entry (valid while not empty)
//   o_fifo_rd       one-cycle pop strobe to the length FIFO
//   o_reg_read_addr packet memory read address (holds when not reading)
//   i_reg_data      packet memory read data, one cycle after the address
//   o_tx_en         transmit byte valid
//   o_txd           transmit byte (0 when o_tx_en is low)
//   o_tx_last       marks the final byte of a packet
//   o_busy          high whenever the reader is not idle
//   o_pkt_count     number of packets fully transmitted (wraps)
// ============================================================================
module packet_mem_reader #(
    parameter int unsigned pLEN_W  = 11,
    parameter int unsigned pADDR_W = 14,
    parameter int unsigned pIFG    = 12,
    parameter int unsigned pCNT_W  = 16
) (
    input  logic               iclk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_fifo_empty,
    input  logic [pLEN_W-1:0]  i_fifo_len,
    output logic               o_fifo_rd,
    output logic [pADDR_W-1:0] o_reg_read_addr,
    input  logic [7:0]         i_reg_data,
    output logic               o_tx_en,
    output logic [7:0]         o_txd,
    output logic               o_tx_last,
    output logic               o_busy,
    output logic [pCNT_W-1:0]  o_pkt_count
);

    // Gap counter runs 0 .. pIFG-1.
    localparam int unsigned GAP_W = (pIFG > 1) ? $clog2(pIFG) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(pIFG - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [pADDR_W-1:0] base_q,    base_d;
    logic [pADDR_W-1:0] addr_q,    addr_d;
    logic [pLEN_W-1:0]  len_q,     len_d;
    logic [pLEN_W-1:0]  issued_q,  issued_d;
    logic [GAP_W-1:0]   gap_q,     gap_d;
    logic               tx_en_q,   tx_en_d;
    logic               tx_last_q, tx_last_d;
    logic               busy_q,    busy_d;
    logic [pCNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic               pop_c;

    // State and datapath registers.
    always_ff @(posedge iclk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            issued_q  <= '0;
            gap_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_last_q <= 1'b0;
            busy_q    <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            issued_q  <= issued_d;
            gap_q     <= gap_d;
            tx_en_q   <= tx_en_d;
            tx_last_q <= tx_last_d;
            busy_q    <= busy_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        addr_d    = addr_q;
        len_d     = len_q;
        issued_d  = issued_q;
        gap_d     = gap_q;
        pkt_cnt_d = pkt_cnt_q;
        tx_en_d   = 1'b0;
        tx_last_d = 1'b0;
        pop_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The pop is taken in the same cycle the head entry is seen.
                // This lets a zero-length entry be discarded and the next
                // entry be evaluated on the following cycle without
                // double-popping.
                if (i_enable && !i_fifo_empty) begin
                    pop_c = 1'b1;
                    if (i_fifo_len != '0) begin
                        len_d    = i_fifo_len;
                        addr_d   = base_q;
                        issued_d = pLEN_W'(1);
                        state_d  = ST_READ;
                    end
                end
            end

            ST_READ: begin
                // Each issued address produces one byte a cycle later.
                // The valid bit follows the address by one register stage.
                tx_en_d = 1'b1;
                if (issued_q == len_q) begin
                    tx_last_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else begin
                    addr_d   = addr_q + pADDR_W'(1);
                    issued_d = issued_q + pLEN_W'(1);
                end
            end

            ST_DRAIN: begin
                base_d    = base_q + pADDR_W'(len_q);
                pkt_cnt_d = pkt_cnt_q + pCNT_W'(1);
                gap_d     = '0;
                state_d   = ST_GAP;
            end

            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Pop is suppressed while reset is held, because the state register sits
    // in IDLE during that time.
    assign o_fifo_rd = pop_c & ~i_rst;

    // The memory's synchronous read register is the data pipeline stage.
    // The byte is gated by the registered valid, so txd reads 0 when idle
    // and drops to 0 at once on reset.
    assign o_txd = tx_en_q ? i_reg_data : 8'h00;

    assign o_reg_read_addr = addr_q;
    assign o_tx_en         = tx_en_q;
    assign o_tx_last       = tx_last_q;
    assign o_busy          = busy_q;
    assign o_pkt_count     = pkt_cnt_q;

endmodule

// File: doc/packet_mem_reader.md
Name: packet_mem_reader

Overview:
- Transmit-side counterpart of the receive packet memory writer.
- Pops packet lengths from the length FIFO and reads the matching bytes from the 14-bit-addressed packet register memory.
- Streams those bytes out as a byte-wide transmit stream (tx_en/txd), with a programmable inter-frame gap between packets.
- Keeps its own read-base pointer, which advances by each packet length so that consecutive packets are read back-to-back.

Parameters:
- pLEN_W, 11: width of the packet length word from the FIFO.
- pADDR_W, 14: packet memory address width; addresses wrap modulo 2^pADDR_W.
- pIFG, 12: idle cycles inserted after each packet (minimum 1).
- pCNT_W, 16: width of the transmitted-packet counter.

Ports:
- iclk, input, 1: clock; all logic on its rising edge.
- i_rst, input, 1: reset, asynchronous, active-high.
- i_enable, input, 1: when 1, new packets may start; a packet already in flight always completes.
- i_fifo_empty, input, 1: length FIFO empty flag.
- i_fifo_len, input, pLEN_W: head entry of the length FIFO. It is first-word-fall-through: valid whenever i_fifo_empty=0.
- o_fifo_rd, output, 1: one-cycle pop strobe to the length FIFO.
- o_reg_read_addr, output, pADDR_W: read address into the packet memory.
- i_reg_data, input, 8: packet memory read data. Synchronous read: data appears 1 cycle after the address.
- o_tx_en, output, 1: transmit data valid.
- o_txd, output, 8: transmit byte.
- o_tx_last, output, 1: high together with the final byte of a packet.
- o_busy, output, 1: high in every state except IDLE.
- o_pkt_count, output, pCNT_W: number of packets fully transmitted; wraps.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-packet):
  - state=IDLE, base pointer=0.
  - o_fifo_rd=0, o_reg_read_addr=0, o_tx_en=0, o_txd=0, o_tx_last=0, o_busy=0, o_pkt_count=0.
  - A packet in flight is abandoned and is not counted.
- States: IDLE, READ, DRAIN, GAP.
- IDLE:
  - If i_enable=1 and i_fifo_empty=0: latch len=i_fifo_len, pulse o_fifo_rd for exactly 1 cycle.
  - If len=0: the entry is discarded. Stay in IDLE; the base pointer is unchanged and no tx activity occurs.
  - If len≠0: go to READ.
  - Otherwise remain in IDLE with all strobes low.
- READ:
  - Issue addresses base, base+1, ... base+len-1 (mod 2^pADDR_W), one per cycle.
  - The cycle after the last address is issued, go to DRAIN.
- Output pipeline:
  - o_tx_en and o_txd are registered from i_reg_data, which is valid 1 cycle after its address.
  - Resulting timing: pop at cycle T, first address at T+1, first byte on o_txd at T+2 with o_tx_en=1.
  - o_tx_en stays high for exactly len consecutive cycles. The last byte is at T+1+len, with o_tx_last=1.
- DRAIN:
  - Lasts 1 cycle, used to emit the final byte.
  - In that cycle: base ← base+len (mod 2^pADDR_W), o_pkt_count increments, go to GAP.
- GAP:
  - Hold o_tx_en=0 for pIFG cycles, counted from the cycle after the last byte, then go to IDLE.
  - FIFO entries present during GAP wait; they are not popped early.
- When o_tx_en=0: o_txd=0 and o_tx_last=0.
- o_reg_read_addr holds its last value when not in READ.
- Lengths: len is used as unsigned. A len larger than 2^pADDR_W is not checked; reads wrap through memory.
- i_enable deassertion:
  - During READ, DRAIN or GAP it has no effect on the current packet.
  - It only blocks the IDLE→READ transition.
- i_fifo_empty toggling mid-packet is ignored; the length was latched at pop.
- Back-to-back packets: the second pop happens in the first IDLE cycle after GAP. The minimum packet-to-packet spacing is therefore pIFG+2 idle cycles on o_tx_en (GAP, the IDLE pop cycle, then the first address cycle).
- Base-pointer wrap: 0x3FFE + 4 → 0x0002. Addresses issued are 3FFE, 3FFF, 0000, 0001.

Test Plan:
- Reset, then FIFO holds len=4 with mem[0..3]=A0,A1,A2,A3:
  - o_fifo_rd pulses once.
  - o_tx_en is high for 4 cycles starting 2 cycles after the pop, with o_txd=A0..A3.
  - o_tx_last is high with A3; o_pkt_count=1; base=4.
- Two queued lengths, 3 then 2, pIFG=12:
  - The second packet reads addresses 3,4.
  - Exactly 14 cycles of o_tx_en=0 between A2's last byte and the next first byte.
  - o_pkt_count=2.
- len=0 entry followed by len=1:
  - The zero entry is popped with no tx_en activity and base is unchanged.
  - The len=1 packet outputs mem[base] with tx_en and tx_last high in the same single cycle.
- Wrap case: base preloaded to 0x3FFE via prior packets, len=4:
  - Addresses 3FFE, 3FFF, 0000, 0001 are issued.
  - base ends at 0x0002.
- i_enable=0 with a non-empty FIFO:
  - No pop and o_busy=0.
  - Raise i_enable: pop on the next cycle.
  - Drop i_enable mid-packet: the packet completes in full.
- Assert i_rst asynchronously on the 3rd byte of a len=8 packet:
  - o_tx_en drops to 0 immediately, without waiting for a clock edge.
  - o_pkt_count=0 and base=0.
  - After release, the next FIFO entry is read from address 0.
